// File: rtl/fpu_issue_ctrl_if.sv
// Handshake and data bundle between the core, the issue controller, the FPU
// and the writeback stage. The slave view belongs to the issue controller;
// the master view is its environment (core, FPU and writeback).
interface fpu_issue_ctrl_if;
    // core request channel
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;
    // FPU launch and completion
    logic        fpu_start;
    logic [2:0]  fpu_op;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [31:0] fpu_result;
    logic        fpu_overflow;
    logic        fpu_underflow;
    logic        fpu_done;
    // writeback channel
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_of;
    logic        wb_uf;
    logic        wb_timeout;
    // sticky exception flags and status
    logic        flag_of;
    logic        flag_uf;
    logic        flag_clr;
    logic        busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd,
        output req_ready,
        output fpu_start, fpu_op, fpu_a, fpu_b,
        input  fpu_result, fpu_overflow, fpu_underflow, fpu_done,
        output wb_valid, wb_data, wb_rd, wb_of, wb_uf, wb_timeout,
        input  wb_ready,
        output flag_of, flag_uf, busy,
        input  flag_clr
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_rd,
        input  req_ready,
        input  fpu_start, fpu_op, fpu_a, fpu_b,
        output fpu_result, fpu_overflow, fpu_underflow, fpu_done,
        input  wb_valid, wb_data, wb_rd, wb_of, wb_uf, wb_timeout,
        output wb_ready,
        input  flag_of, flag_uf, busy,
        output flag_clr
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Single-operation FPU issue controller: accepts one request from the core,
// launches it on the FPU, waits for completion (or aborts after TIMEOUT
// cycles with a quiet NaN), then holds the result until writeback takes it.
// Overflow/underflow of completed operations accumulate into sticky flags.
module fpu_issue_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic             clk,
    input logic             rst,
    fpu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        req_ready_q;
    logic        fpu_start_q;
    logic        busy_q;
    logic        wb_valid_q;
    logic [2:0]  fpu_op_q;
    logic [31:0] fpu_a_q;
    logic [31:0] fpu_b_q;
    logic [4:0]  rd_q;
    logic [31:0] wb_data_q;
    logic        wb_of_q;
    logic        wb_uf_q;
    logic        wb_timeout_q;
    logic        flag_of_q;
    logic        flag_uf_q;
    logic        flag_of_d;
    logic        flag_uf_d;

    // Sticky flag update on a completion: a new exception survives a
    // simultaneous clear, otherwise the clear applies.
    always_comb begin
        flag_of_d = (bus.flag_clr ? 1'b0 : flag_of_q) | bus.fpu_overflow;
        flag_uf_d = (bus.flag_clr ? 1'b0 : flag_uf_q) | bus.fpu_underflow;
    end

    // Issue FSM with all handshake/status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            fpu_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            fpu_op_q     <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            rd_q         <= '0;
            wb_data_q    <= '0;
            wb_of_q      <= 1'b0;
            wb_uf_q      <= 1'b0;
            wb_timeout_q <= 1'b0;
            flag_of_q    <= 1'b0;
            flag_uf_q    <= 1'b0;
        end else begin
            // a plain clear applies in any state; a completion below overrides it
            if (bus.flag_clr) begin
                flag_of_q <= 1'b0;
                flag_uf_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        fpu_op_q    <= bus.req_op;
                        fpu_a_q     <= bus.req_a;
                        fpu_b_q     <= bus.req_b;
                        rd_q        <= bus.req_rd;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        fpu_start_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    fpu_start_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (bus.fpu_done) begin
                        // completion has priority over a coincident timeout
                        wb_data_q    <= bus.fpu_result;
                        wb_of_q      <= bus.fpu_overflow;
                        wb_uf_q      <= bus.fpu_underflow;
                        wb_timeout_q <= 1'b0;
                        flag_of_q    <= flag_of_d;
                        flag_uf_q    <= flag_uf_d;
                        wb_valid_q   <= 1'b1;
                        state_q      <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        wb_data_q    <= QNAN;
                        wb_of_q      <= 1'b0;
                        wb_uf_q      <= 1'b0;
                        wb_timeout_q <= 1'b1;
                        wb_valid_q   <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.wb_ready) begin
                        wb_valid_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.fpu_start  = fpu_start_q;
    assign bus.fpu_op     = fpu_op_q;
    assign bus.fpu_a      = fpu_a_q;
    assign bus.fpu_b      = fpu_b_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_rd      = rd_q;
    assign bus.wb_of      = wb_of_q;
    assign bus.wb_uf      = wb_uf_q;
    assign bus.wb_timeout = wb_timeout_q;
    assign bus.flag_of    = flag_of_q;
    assign bus.flag_uf    = flag_uf_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: the stimulus process plays both the core and the
// FPU, pushing the expected writeback into a scoreboard; an independent
// monitor pops and compares on every writeback handshake.
module tb_fpu_issue_ctrl;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if bus ();
    fpu_issue_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        of;
        logic        uf;
        logic        to;
        logic        fof;
        logic        fuf;
    } resp_t;

    resp_t sb_q[$];
    int    checks = 0;
    int    passed = 0;
    int    starts = 0;
    int    issued = 0;
    int    txn_no = 0;
    logic  mf_of  = 1'b0;
    logic  mf_uf  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // monitor: counts launch pulses and checks every writeback handshake
    initial begin
        forever begin
            resp_t got;
            resp_t exp;
            @(negedge clk);
            #1;
            if (!rst && bus.fpu_start === 1'b1) starts++;
            if (bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
                got = {bus.wb_data, bus.wb_rd, bus.wb_of, bus.wb_uf, bus.wb_timeout,
                       bus.flag_of, bus.flag_uf};
                txn_no++;
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL wb_unexpected: got %h expected no response", got);
                end else begin
                    exp = sb_q.pop_front();
                    chk("wb_resp", 64'(got), 64'(exp));
                    $display("txn %0d rd=%0d data=%h of=%b uf=%b to=%b flags=%b%b",
                             txn_no, got.rd, got.data, got.of, got.uf, got.to, got.fof, got.fuf);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_fpu();
        bus.fpu_done      = 1'b0;
        bus.fpu_overflow  = 1'b0;
        bus.fpu_underflow = 1'b0;
        bus.flag_clr      = 1'b0;
    endtask

    // k = WAIT cycle on which fpu_done is pulsed; k > TO means timeout
    // (k == TO+1 additionally pulses a stray fpu_done during RESP)
    task automatic run_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input int k, input logic [31:0] res,
                           input logic of, input logic uf, input logic clr,
                           input int bp, input logic spur);
        resp_t       e;
        int          n;
        logic [31:0] hold;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            checks++;
            $display("FAIL req_ready_wait: got %b expected 1", bus.req_ready);
            return;
        end
        if (spur) begin
            bus.fpu_done = 1'b1; bus.fpu_overflow = 1'b1; bus.fpu_underflow = 1'b1;
            @(negedge clk);
            clear_fpu();
            chk("spur_idle_busy", bus.busy, 0);
            chk("spur_idle_ready", bus.req_ready, 1);
        end
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_rd = rd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        issued++;
        chk("issue_start", bus.fpu_start, 1);
        chk("issue_operands", {bus.fpu_op, bus.fpu_a, bus.fpu_b}, {op, a, b});
        chk("issue_req_ready", bus.req_ready, 0);
        if (spur) begin
            bus.fpu_done = 1'b1; bus.fpu_result = 32'hDEAD_BEEF;
            bus.fpu_overflow = 1'b1; bus.fpu_underflow = 1'b1;
        end
        for (int w = 1; w <= TO && w <= k; w++) begin
            @(negedge clk);
            clear_fpu();
            chk("wait_wb_valid", bus.wb_valid, 0);
            chk("wait_start", bus.fpu_start, 0);
            if (w == k) begin
                bus.fpu_done = 1'b1; bus.fpu_result = res;
                bus.fpu_overflow = of; bus.fpu_underflow = uf; bus.flag_clr = clr;
            end
        end
        if (k <= TO) begin
            if (clr) {mf_of, mf_uf} = {of, uf};
            else begin mf_of = mf_of | of; mf_uf = mf_uf | uf; end
            e = {res, rd, of, uf, 1'b0, mf_of, mf_uf};
        end else begin
            e = {32'h7FC0_0000, rd, 1'b0, 1'b0, 1'b1, mf_of, mf_uf};
        end
        sb_q.push_back(e);
        bus.wb_ready = (bp == 0);
        @(negedge clk);
        clear_fpu();
        chk("resp_wb_valid", bus.wb_valid, 1);
        if (k == TO + 1) begin
            bus.fpu_done = 1'b1; bus.fpu_result = 32'h1234_5678;
            bus.fpu_overflow = 1'b1; bus.fpu_underflow = 1'b1;
        end
        hold = bus.wb_data;
        for (int i = 0; i < bp; i++) begin
            chk("bp_req_ready", bus.req_ready, 0);
            bus.req_valid = 1'b1; bus.req_a = $urandom;
            @(negedge clk);
            clear_fpu();
            chk("bp_hold", {bus.wb_valid, bus.wb_data}, {1'b1, hold});
        end
        bus.req_valid = 1'b0;
        bus.wb_ready  = 1'b1;
        @(negedge clk);
        clear_fpu();
        bus.wb_ready = 1'b0;
        chk("post_state", {bus.req_ready, bus.wb_valid, bus.busy}, 3'b100);
    endtask

    initial begin
        bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0; bus.req_rd = 0;
        bus.fpu_result = 0; bus.wb_ready = 0;
        clear_fpu();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.fpu_op, bus.fpu_a, bus.fpu_b, bus.wb_data, bus.wb_rd},
            '0);
        chk("reset_status", {bus.wb_of, bus.wb_uf, bus.wb_timeout, bus.flag_of, bus.flag_uf,
                             bus.fpu_start, bus.wb_valid, bus.busy}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", bus.req_ready, 1);

        // basic operation: 1.0 + 2.0 = 3.0 after 4 WAIT cycles
        run_txn(3'd1, 32'h3F80_0000, 32'h4000_0000, 5'd5, 4, 32'h4040_0000, 0, 0, 0, 0, 0);
        // overflow and sticky flag behaviour
        run_txn(3'd2, 32'h7F00_0000, 32'h7F00_0000, 5'd7, 3, 32'h7F7F_FFFF, 1, 0, 0, 0, 0);
        chk("flag_of_set", bus.flag_of, 1);
        bus.flag_clr = 1'b1;
        @(negedge clk);
        bus.flag_clr = 1'b0;
        mf_of = 1'b0; mf_uf = 1'b0;
        chk("flag_clr", {bus.flag_of, bus.flag_uf}, 2'b00);
        run_txn(3'd2, 32'h7F00_0000, 32'h7F00_0000, 5'd8, 2, 32'h7F7F_FFFF, 1, 0, 1, 0, 0);
        run_txn(3'd3, 32'h0080_0000, 32'h0080_0000, 5'd9, 1, 32'h0000_0000, 0, 1, 0, 0, 0);
        // timeout (with stray done in RESP), done on the last WAIT cycle, plain timeout
        run_txn(3'd4, 32'h1, 32'h2, 5'd10, TO + 1, 32'h0, 0, 0, 0, 0, 0);
        run_txn(3'd4, 32'h3, 32'h4, 5'd11, TO, 32'h4100_0000, 0, 0, 0, 0, 0);
        run_txn(3'd4, 32'h5, 32'h6, 5'd12, TO + 2, 32'h0, 0, 0, 0, 0, 0);
        // backpressure and spurious completions
        run_txn(3'd5, 32'h4080_0000, 32'h3F00_0000, 5'd13, 5, 32'h4000_0000, 0, 0, 0, 5, 0);
        run_txn(3'd6, 32'h4000_0000, 32'h4000_0000, 5'd14, 2, 32'h4080_0000, 0, 0, 0, 1, 1);
        run_txn(3'd7, 32'h4000_0000, 32'h4040_0000, 5'd15, 6, 32'h40C0_0000, 0, 0, 0, 0, 1);

        for (int t = 0; t < 30; t++) begin
            run_txn(3'($urandom), $urandom, $urandom, 5'($urandom), int'($urandom_range(1, 10)),
                    $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0));
        end

        // make sure the flags are set so the reset clearing is observable
        run_txn(3'd1, 32'h1, 32'h1, 5'd31, 2, 32'h7F7F_FFFF, 1, 1, 0, 0, 0);
        // abort from WAIT via reset, then a stray done in IDLE
        bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_a = 32'hAAAA_5555;
        bus.req_b = 32'h5555_AAAA; bus.req_rd = 5'd21;
        @(negedge clk);
        bus.req_valid = 1'b0;
        issued++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mf_of = 1'b0; mf_uf = 1'b0;
        chk("abort_outputs", {bus.fpu_op, bus.fpu_a, bus.fpu_b, bus.wb_data, bus.wb_rd}, '0);
        chk("abort_status", {bus.wb_of, bus.wb_uf, bus.wb_timeout, bus.flag_of, bus.flag_uf,
                             bus.fpu_start, bus.wb_valid, bus.busy}, 8'h00);
        chk("abort_req_ready", bus.req_ready, 1);
        bus.fpu_done = 1'b1; bus.fpu_result = 32'h3F80_0000;
        bus.fpu_overflow = 1'b1; bus.fpu_underflow = 1'b1;
        @(negedge clk);
        clear_fpu();
        @(negedge clk);
        chk("abort_stray_done", {bus.wb_valid, bus.busy, bus.flag_of, bus.flag_uf}, 4'b0000);
        run_txn(3'd1, 32'h3F80_0000, 32'h3F80_0000, 5'd3, 3, 32'h4000_0000, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("start_pulses", starts, issued);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 64, max WAIT cycles before abort (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core presents an FPU operation.
REQ-005 req_ready  output  1  block can accept an operation.
REQ-006 req_op  input  3  FPU operation code, passed through unchanged.
REQ-007 req_a / req_b  input  32 each  single-precision operands.
REQ-008 req_rd  input  5  destination register tag.
REQ-009 fpu_start  output  1  one-cycle launch pulse to the FPU.
REQ-010 fpu_op / fpu_a / fpu_b  output  3/32/32  registered operands to the FPU.
REQ-011 fpu_result  input  32  FPU registered result, already saturated: 0x00000000 on underflow, 0x7F7FFFFF on overflow.
REQ-012 fpu_overflow / fpu_underflow  input  1 each  status aligned with fpu_result.
REQ-013 fpu_done  input  1  completion strobe (done_cal), qualifies result and status.
REQ-014 wb_valid  output  1  writeback result available.
REQ-015 wb_ready  input  1  writeback stage accepts the result.
REQ-016 wb_data / wb_rd  output  32/5  result and destination tag.
REQ-017 wb_of / wb_uf / wb_timeout  output  1 each  per-result status.
REQ-018 flag_of / flag_uf  output  1 each  sticky accumulated exception flags.
REQ-019 flag_clr  input  1  clears the sticky flags.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-022 IDLE: req_ready=1; on req_valid, capture req_op/a/b/rd into fpu_op/a/b and the tag register -> ISSUE.
REQ-023 req_ready SHALL be 0 in ISSUE, WAIT and RESP; req_valid is ignored there.
REQ-024 ISSUE: fpu_start=1 for exactly one cycle, wait counter cleared -> WAIT; fpu_start=0 in all other states.
REQ-025 fpu_op/a/b SHALL hold their values from capture until the next capture.
REQ-026 WAIT, fpu_done=1: latch wb_data=fpu_result, wb_of=fpu_overflow, wb_uf=fpu_underflow, wb_timeout=0 -> RESP.
REQ-027 WAIT, fpu_done=0: counter increments; when the counter equals TIMEOUT-1 -> RESP with wb_data=0x7FC00000, wb_of=0, wb_uf=0, wb_timeout=1.
REQ-028 If fpu_done=1 in the same cycle the counter reaches TIMEOUT-1, the completion SHALL win (REQ-026).
REQ-029 fpu_done in IDLE, ISSUE or RESP SHALL be ignored, with no state or flag change.
REQ-030 RESP: wb_valid=1 and wb_data/wb_rd/wb_* held stable until wb_ready=1; that cycle -> IDLE.
REQ-031 wb_valid SHALL be 0 in IDLE, ISSUE and WAIT.
REQ-032 Latency: request accepted in cycle N, fpu_start in N+1, WAIT from N+2; fpu_done in cycle M gives wb_valid in M+1.
REQ-033 Back-to-back: req_ready rises the cycle after the wb handshake; there is no IDLE bypass.
REQ-034 Sticky flags: flag_of|=fpu_overflow and flag_uf|=fpu_underflow on a REQ-026 capture; flag_clr zeroes both; set wins over a simultaneous clear.
REQ-035 Timeout SHALL NOT set the sticky flags.

Reset
REQ-036 While rst=1 at a clock edge: state=IDLE, counter=0, and every output 0 (fpu_op/a/b, wb_data, wb_rd, wb_of, wb_uf, wb_timeout, flag_of, flag_uf, fpu_start, wb_valid, busy); req_ready=1 from the first cycle after reset.
REQ-037 Reset in any state SHALL abort the operation; a later fpu_done SHALL be ignored per REQ-029.

Verification
REQ-038 Basic op: req a=0x3F800000, b=0x40000000, rd=5; fpu_done after 4 WAIT cycles with 0x40400000 -> wb_valid with wb_data=0x40400000, wb_rd=5, wb_of=0, wb_uf=0.
REQ-039 Overflow: fpu_done with 0x7F7FFFFF and fpu_overflow=1 -> wb_of=1, flag_of=1; flag_clr -> flag_of=0 next cycle; flag_clr coincident with a new overflow capture -> flag_of stays 1.
REQ-040 Timeout with TIMEOUT=8 and no fpu_done -> wb_valid in the cycle after the 8th WAIT cycle with wb_data=0x7FC00000, wb_timeout=1, flags unchanged; fpu_done on the 8th WAIT cycle -> normal result, wb_timeout=0.
REQ-041 Backpressure: wb_ready=0 for 5 cycles -> wb_valid and wb_data held, req_ready=0 and a new req_valid ignored; wb_ready=1 -> IDLE, req_ready=1 next cycle.
REQ-042 rst=1 during WAIT, then fpu_done pulse in IDLE -> all outputs 0, no wb_valid; a following request completes normally.
REQ-043 Spurious fpu_done in IDLE and ISSUE -> no state change, fpu_start pulses exactly once per request.
